// File: rtl/alu_pkg.sv
// Shared ALU definitions: M-extension divide/remainder op codes, the divide
// sequencer state encoding, and op-class decode helpers.
package alu_pkg;

    localparam logic [5:0] OP_DIV   = 6'b100011;
    localparam logic [5:0] OP_DIVU  = 6'b100100;
    localparam logic [5:0] OP_REM   = 6'b100101;
    localparam logic [5:0] OP_REMU  = 6'b100110;
    localparam logic [5:0] OP_DIVW  = 6'b101000;
    localparam logic [5:0] OP_DIVUW = 6'b101001;
    localparam logic [5:0] OP_REMW  = 6'b101010;
    localparam logic [5:0] OP_REMUW = 6'b101011;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } divState_e;

    function automatic logic isDivOp(input logic [5:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic isWOp(input logic [5:0] op);
        return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic isSignedOp(input logic [5:0] op);
        return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic isRemOp(input logic [5:0] op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/div_core.sv
// Restoring shift/subtract divider datapath: load aligns the unsigned
// operands, each step retires one quotient bit into the low end of quoReg.
module div_core #(
    parameter int unsigned BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      load,
    input  logic                      step,
    input  logic [BUS_DATA_WIDTH-1:0] dividend,
    input  logic [BUS_DATA_WIDTH-1:0] divisor,
    output logic [BUS_DATA_WIDTH-1:0] quotient,
    output logic [BUS_DATA_WIDTH-1:0] remainder
);

    localparam int unsigned W = BUS_DATA_WIDTH;

    logic [W-1:0] quoReg;
    logic [W-1:0] remReg;
    logic [W-1:0] divReg;
    logic [W:0]   shifted;
    logic [W:0]   trial;

    // Trial subtraction of the divisor from the shifted partial remainder;
    // trial[W] set means the subtraction went negative (restore).
    always_comb begin
        shifted = {remReg, quoReg[W-1]};
        trial   = shifted - {1'b0, divReg};
    end

    // Operand load and one restoring iteration per step.
    always_ff @(posedge clk) begin
        if (load) begin
            quoReg <= dividend;
            remReg <= '0;
            divReg <= divisor;
        end else if (step) begin
            quoReg <= {quoReg[W-2:0], ~trial[W]};
            remReg <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
        end
    end

    assign quotient  = quoReg;
    assign remainder = remReg;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle integer divide/remainder sequencer for the execute stage.
// Optional feature: define DIV_RESULT_CACHE_EN to keep the last completed
// quotient/remainder pair and answer a matching request without iterating.
module div_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [5:0]                inAluControl,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg1,
    input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
    input  logic [4:0]                inDestRegister,
    input  logic                      inFlush,
    output logic                      outStall,
    output logic                      outBusy,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [4:0]                outDestRegister
);

    localparam int unsigned W  = BUS_DATA_WIDTH;
    localparam int unsigned CW = $clog2(W) + 1;

    function automatic logic [W-1:0] sext32(input logic [W-1:0] x);
        return {{(W-32){x[31]}}, x[31:0]};
    endfunction

    function automatic logic [W-1:0] fitWidth(input logic w, input logic [W-1:0] x);
        return w ? sext32(x) : x;
    endfunction

    divState_e     state, stateNext;
    logic [5:0]    opReg;
    logic [W-1:0]  aReg, bReg;
    logic [4:0]    destReg;
    logic [W-1:0]  qRes, rRes;
    logic [CW-1:0] cnt;

    logic          opW, opSigned, opRem;
    logic [W-1:0]  aExt, bExt, aMag, bMag, coreDividend, minNeg;
    logic          aNeg, bNeg, divZero, overflow;
    logic [W-1:0]  coreQuo, coreRem, qSigned, rSigned;
    logic          coreLoad, coreStep;
    logic          accept, cacheHit;
    logic [W-1:0]  hitQ, hitR;

    assign opW      = isWOp(opReg);
    assign opSigned = isSignedOp(opReg);
    assign opRem    = isRemOp(opReg);
    assign accept   = inValid && isDivOp(inAluControl) && !inFlush;

    // Operand extension, magnitudes, special-case detection and sign fix-up.
    // W dividends are parked in the upper half so 32 steps leave the
    // quotient in the low half.
    always_comb begin
        aExt = opW ? (opSigned ? sext32(aReg) : {{(W-32){1'b0}}, aReg[31:0]}) : aReg;
        bExt = opW ? (opSigned ? sext32(bReg) : {{(W-32){1'b0}}, bReg[31:0]}) : bReg;
        aNeg = opSigned && aExt[W-1];
        bNeg = opSigned && bExt[W-1];
        aMag = aNeg ? -aExt : aExt;
        bMag = bNeg ? -bExt : bExt;
        coreDividend = opW ? {aMag[31:0], {(W-32){1'b0}}} : aMag;
        minNeg   = opW ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
        divZero  = (bExt == '0);
        overflow = opSigned && (aExt == minNeg) && (bExt == '1);
        qSigned  = (aNeg ^ bNeg) ? -coreQuo : coreQuo;
        rSigned  = aNeg ? -coreRem : coreRem;
    end

    div_core #(
        .BUS_DATA_WIDTH(W)
    ) uCore (
        .clk      (clk),
        .load     (coreLoad),
        .step     (coreStep),
        .dividend (coreDividend),
        .divisor  (bMag),
        .quotient (coreQuo),
        .remainder(coreRem)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic         cacheValid, cacheSigned, cacheW;
    logic [W-1:0] cacheA, cacheB, cacheQ, cacheR;

    assign cacheHit = cacheValid && (inDataReg1 == cacheA) && (inDataReg2 == cacheB) &&
                      (isSignedOp(inAluControl) == cacheSigned) &&
                      (isWOp(inAluControl) == cacheW);
    assign hitQ = cacheQ;
    assign hitR = cacheR;

    // Capture the pair only once an operation is actually delivered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cacheValid  <= 1'b0;
            cacheSigned <= 1'b0;
            cacheW      <= 1'b0;
            cacheA      <= '0;
            cacheB      <= '0;
            cacheQ      <= '0;
            cacheR      <= '0;
        end else if (state == DONE && !inFlush) begin
            cacheValid  <= 1'b1;
            cacheSigned <= opSigned;
            cacheW      <= opW;
            cacheA      <= aReg;
            cacheB      <= bReg;
            cacheQ      <= qRes;
            cacheR      <= rRes;
        end
    end
`else
    assign cacheHit = 1'b0;
    assign hitQ     = '0;
    assign hitR     = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state, stall and datapath control; a flush overrides everything.
    always_comb begin
        stateNext = state;
        outStall  = 1'b0;
        coreLoad  = 1'b0;
        coreStep  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    outStall  = 1'b1;
                    stateNext = cacheHit ? DONE : PREP;
                end
            end
            PREP: begin
                outStall  = 1'b1;
                coreLoad  = 1'b1;
                stateNext = (divZero || overflow) ? DONE : ITER;
            end
            ITER: begin
                outStall = 1'b1;
                coreStep = 1'b1;
                if (cnt == CW'(1)) stateNext = FIX;
            end
            FIX: begin
                outStall  = 1'b1;
                stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (inFlush) stateNext = IDLE;
    end

    // Request capture, iteration count and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            opReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            destReg <= '0;
            qRes    <= '0;
            rRes    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg   <= inAluControl;
                        aReg    <= inDataReg1;
                        bReg    <= inDataReg2;
                        destReg <= inDestRegister;
                        if (cacheHit) begin
                            qRes <= hitQ;
                            rRes <= hitR;
                        end
                    end
                end
                PREP: begin
                    cnt <= opW ? CW'(32) : CW'(W);
                    if (divZero) begin
                        qRes <= '1;
                        rRes <= fitWidth(opW, aExt);
                    end else if (overflow) begin
                        qRes <= fitWidth(opW, aExt);
                        rRes <= '0;
                    end
                end
                ITER: cnt <= cnt - CW'(1);
                FIX: begin
                    qRes <= fitWidth(opW, qSigned);
                    rRes <= fitWidth(opW, rSigned);
                end
                default: ;
            endcase
        end
    end

    assign outValid        = (state == DONE) && !inFlush;
    assign outBusy         = (state != IDLE);
    assign outResult       = opRem ? rRes : qRes;
    assign outDestRegister = destReg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomised bench for div_sequencer with a result scoreboard;
// honours DIV_RESULT_CACHE_EN when predicting latency.
module tb_div_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [5:0]  inAluControl;
    logic [63:0] inDataReg1, inDataReg2;
    logic [4:0]  inDestRegister;
    logic        inFlush;
    logic        outStall, outBusy, outValid;
    logic [63:0] outResult;
    logic [4:0]  outDestRegister;

    always #5 clk = ~clk;

    div_sequencer #(.BUS_DATA_WIDTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .inValid        (inValid),
        .inAluControl   (inAluControl),
        .inDataReg1     (inDataReg1),
        .inDataReg2     (inDataReg2),
        .inDestRegister (inDestRegister),
        .inFlush        (inFlush),
        .outStall       (outStall),
        .outBusy        (outBusy),
        .outValid       (outValid),
        .outResult      (outResult),
        .outDestRegister(outDestRegister)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dest;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int          testCount = 0;
    int          failCount = 0;

    // reference model of the last delivered pair's key
    bit          cValid = 1'b0;
    logic [63:0] cA, cB;
    bit          cS, cW;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit opIsW(input logic [5:0] op);
        return op inside {6'b101000, 6'b101001, 6'b101010, 6'b101011};
    endfunction
    function automatic bit opIsSigned(input logic [5:0] op);
        return op inside {6'b100011, 6'b100101, 6'b101000, 6'b101010};
    endfunction
    function automatic bit opIsRem(input logic [5:0] op);
        return op inside {6'b100101, 6'b100110, 6'b101010, 6'b101011};
    endfunction

    function automatic bit refSpecial(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        if (opIsW(op))
            return (b[31:0] == 32'h0) ||
                   (opIsSigned(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) ||
               (opIsSigned(op) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] refResult(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa64, sb64;
        logic [31:0] q32, r32;
        logic [63:0] q64, r64;
        if (opIsW(op)) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'h0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0];
            end else if (opIsSigned(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'h0;
            end else if (opIsSigned(op)) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            return opIsRem(op) ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        sa64 = a;
        sb64 = b;
        if (b == 64'h0) begin
            q64 = '1; r64 = a;
        end else if (opIsSigned(op) && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (opIsSigned(op)) begin
            q64 = sa64 / sb64; r64 = sa64 % sb64;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return opIsRem(op) ? r64 : q64;
    endfunction

    task automatic runOp(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] dest, input logic [63:0] expRes, input string tag);
        exp_t        e;
        bit          hit, seen, stallOk;
        int unsigned cycles;
        hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        hit = cValid && a == cA && b == cB && opIsSigned(op) == cS && opIsW(op) == cW;
`endif
        e.res  = expRes;
        e.dest = dest;
        e.lat  = hit ? 1 : refSpecial(op, a, b) ? 2 : opIsW(op) ? 35 : 67;
        sb.push_back(e);

        @(negedge clk);
        inValid = 1'b1; inAluControl = op; inDataReg1 = a; inDataReg2 = b; inDestRegister = dest;
        #1 check({tag, ".acceptStall"}, 64'(outStall), 64'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inDataReg1 = {$urandom, $urandom};
        inDataReg2 = {$urandom, $urandom};
        inDestRegister = ~dest;

        cycles = 0; seen = 1'b0; stallOk = 1'b1;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (outValid) seen = 1'b1;
            else if (!(outStall && outBusy)) stallOk = 1'b0;
        end
        check({tag, ".validSeen"}, 64'(seen), 64'd1);
        e = sb.pop_front();
        if (seen) begin
            check({tag, ".result"}, outResult, e.res);
            check({tag, ".dest"}, 64'(outDestRegister), 64'(e.dest));
            check({tag, ".latency"}, 64'(cycles), 64'(e.lat));
            check({tag, ".doneStall"}, 64'(outStall), 64'd0);
        end
        check({tag, ".stallHeld"}, 64'(stallOk), 64'd1);
        @(negedge clk);
        check({tag, ".validOneCycle"}, 64'(outValid), 64'd0);
        check({tag, ".idleBusy"}, 64'(outBusy), 64'd0);
        if (seen) begin
            cValid = 1'b1; cA = a; cB = b; cS = opIsSigned(op); cW = opIsW(op);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops[8];
        logic [63:0] ra, rb;
        int          validCount;

        ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        reset = 1'b0; inValid = 1'b0; inAluControl = '0; inDataReg1 = '0; inDataReg2 = '0;
        inDestRegister = '0; inFlush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.valid", 64'(outValid), 64'd0);
        check("reset.stall", 64'(outStall), 64'd0);
        check("reset.busy", 64'(outBusy), 64'd0);
        check("reset.result", outResult, 64'd0);
        check("reset.dest", 64'(outDestRegister), 64'd0);
        reset = 1'b1;

        runOp(OP_DIV,   64'd100, 64'd7, 5'd5, 64'd14, "div");
        runOp(OP_REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, "rem");
        runOp(OP_REMW,  64'h0000_0000_FFFF_FF9C, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, "remw");
        runOp(OP_DIVU,  64'd5, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, "divuZero");
        runOp(OP_REMU,  64'd5, 64'd0, 5'd9, 64'd5, "remuZero");
        runOp(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
              64'h8000_0000_0000_0000, "divOvf");
        runOp(OP_DIVW,  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
              64'hFFFF_FFFF_8000_0000, "divwOvf");
        runOp(OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd2, 5'd12, 64'h0000_0000_7FFF_FFFF, "divuw");
        runOp(OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd13, 64'h5555_5555_5555_5555, "divu");
        runOp(OP_REMW,  64'h1234_5678_0000_0007, 64'd0, 5'd14, 64'd7, "remwZero");

        // unknown op code is ignored
        @(negedge clk);
        inValid = 1'b1; inAluControl = 6'b000001; inDataReg1 = 64'd50; inDataReg2 = 64'd5;
        #1 check("badOp.stall", 64'(outStall), 64'd0);
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        check("badOp.busy", 64'(outBusy), 64'd0);

        // flush together with a valid request in IDLE: no accept
        inValid = 1'b1; inFlush = 1'b1; inAluControl = OP_DIV;
        #1 check("flushIdle.stall", 64'(outStall), 64'd0);
        @(posedge clk);
        #1 begin inValid = 1'b0; inFlush = 1'b0; end
        @(negedge clk);
        check("flushIdle.busy", 64'(outBusy), 64'd0);

        // flush mid-iteration
        inValid = 1'b1; inAluControl = OP_DIV; inDataReg1 = 64'd1000; inDataReg2 = 64'd3;
        inDestRegister = 5'd20;
        @(posedge clk);
        #1 inValid = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        check("flush.busyBefore", 64'(outBusy), 64'd1);
        inFlush = 1'b1;
        @(posedge clk);
        #1 inFlush = 1'b0;
        @(negedge clk);
        check("flush.busy", 64'(outBusy), 64'd0);
        check("flush.stall", 64'(outStall), 64'd0);
        validCount = 0;
        for (int c = 0; c < 80; c++) begin
            if (outValid) validCount++;
            @(negedge clk);
        end
        check("flush.noValid", 64'(validCount), 64'd0);

        // reset mid-operation
        inValid = 1'b1; inAluControl = OP_DIV; inDataReg1 = 64'd200; inDataReg2 = 64'd9;
        inDestRegister = 5'd21;
        @(posedge clk);
        #1 inValid = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midReset.valid", 64'(outValid), 64'd0);
        check("midReset.stall", 64'(outStall), 64'd0);
        check("midReset.busy", 64'(outBusy), 64'd0);
        check("midReset.result", outResult, 64'd0);
        check("midReset.dest", 64'(outDestRegister), 64'd0);
        reset = 1'b1;
        cValid = 1'b0;
        runOp(OP_DIV, 64'd9, 64'd3, 5'd22, 64'd3, "afterReset");

        // same operands, different op: cache hit when the feature is built in
        runOp(OP_DIV, 64'd100, 64'd7, 5'd15, 64'd14, "cacheDiv");
        runOp(OP_REM, 64'd100, 64'd7, 5'd16, 64'd2, "cacheRem");

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(1, 60);
            runOp(ops[i], ra, rb, 5'(i + 1), refResult(ops[i], ra, rb), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, giving the operand and result width.
REQ-002 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-low reset.
REQ-003 SHALL have ports: inValid input 1, request strobe from the execute stage; inAluControl input 6, the op code; inDataReg1 input BUS_DATA_WIDTH, the post-forwarding dividend; inDataReg2 input BUS_DATA_WIDTH, the post-forwarding divisor; inDestRegister input 5; inFlush input 1, pipeline kill.
REQ-004 SHALL have ports: outStall output 1, freezes the fetch/decode/execute stages; outBusy output 1; outValid output 1; outResult output BUS_DATA_WIDTH; outDestRegister output 5.

Function
REQ-005 SHALL accept only these op codes: div 100011, divu 100100, rem 100101, remu 100110, divw 101000, divuw 101001, remw 101010, remuw 101011; inValid with any other code SHALL be ignored.
REQ-006 SHALL implement FSM states IDLE, PREP, ITER, FIX, DONE; on accept in IDLE go to PREP and latch op, operands and destination register.
REQ-007 PREP: W ops extend [31:0] (sign-extend for signed ops, zero-extend otherwise); signed ops take magnitudes; iteration counter N is loaded (64 for 64-bit ops, 32 for W ops); next state ITER, or DONE if a special case applies.
REQ-008 ITER: restoring division, one quotient bit per cycle, exactly N cycles, then FIX.
REQ-009 FIX: negate the quotient if operand signs differ; the remainder takes the dividend's sign; W results are sign-extended from bit 31; next state DONE.
REQ-010 DONE: outValid=1 for exactly one cycle with outResult and outDestRegister valid; next state IDLE; a new request is not accepted in DONE.
REQ-011 Latency: outValid is high in cycle t+N+3, where t is the accepting edge (67 cycles for 64-bit ops, 35 for W ops).
REQ-012 Divide by zero: quotient all-ones and remainder = dividend (W ops use 32-bit semantics, then sign-extend); DONE at t+2.
REQ-013 Signed overflow (most-negative / -1): quotient = dividend and remainder = 0; DONE at t+2.
REQ-014 outStall = (IDLE & inValid & op accepted & !inFlush) | state in {PREP, ITER, FIX}; outStall SHALL be low in DONE.
REQ-015 outBusy SHALL be high whenever state != IDLE.
REQ-016 inFlush in any state SHALL return the FSM to IDLE at the next edge with no outValid; inFlush and inValid together in IDLE means no accept.
REQ-017 Latched operands SHALL NOT change while busy; input changes after accept have no effect.

Reset
REQ-018 reset low at a clock edge SHALL force IDLE, outValid=0, outStall=0, outBusy=0, outResult=0, outDestRegister=0 and clear the cache-valid flag, including mid-operation.

Configuration
REQ-019 When DIV_RESULT_CACHE_EN is defined, the last completed quotient/remainder pair SHALL be stored with its operands, signedness and width; a new request matching all of these SHALL go IDLE->DONE, with outValid at t+1.
REQ-020 When DIV_RESULT_CACHE_EN is undefined, no cache storage SHALL exist and every request follows REQ-011 to REQ-013.
REQ-021 A flushed or reset operation SHALL never update the cache.

Structure
REQ-022 The shared package alu_pkg SHALL hold the M-extension op code constants, the FSM state enum and the W-op/signed decode helpers.
REQ-023 The shift/subtract datapath SHALL be one sub-module, div_core; the FSM, special-case and cache logic SHALL stay in div_sequencer.

Verification
REQ-024 div 100/7 -> outResult 14, outValid at t+67, outStall high for cycles t..t+66.
REQ-025 rem -100/7 -> -2; remw 0x00000000_FFFFFF9C / 7 -> 0xFFFFFFFF_FFFFFFFE at t+35.
REQ-026 divu 5/0 -> 0xFFFFFFFF_FFFFFFFF at t+2; remu 5/0 -> 5; div 0x80000000_00000000 / -1 -> 0x80000000_00000000 at t+2.
REQ-027 div accepted, then inFlush at t+10 -> IDLE at t+11, no outValid, outStall low from t+11.
REQ-028 reset low at t+20 of an active divide -> all outputs 0 at the next edge; a new div 9/3 afterwards -> 3 at t'+67.
REQ-029 With DIV_RESULT_CACHE_EN defined: div 100/7, then rem 100/7 -> 2 with outValid at t+1; without the macro the same rem takes 67 cycles.
